// File: rtl/oram_traffic_gen_pkg.sv
// Shared encodings for the ORAM front-end traffic generator: backend commands,
// error codes and controller states.
package oram_traffic_gen_pkg;

  localparam logic [1:0] BECMD_Update  = 2'd0;
  localparam logic [1:0] BECMD_Append  = 2'd1;
  localparam logic [1:0] BECMD_Read    = 2'd2;
  localparam logic [1:0] BECMD_ReadRmv = 2'd3;

  localparam logic [2:0] ErrNone      = 3'd0;
  localparam logic [2:0] ErrMismatch  = 3'd1;
  localparam logic [2:0] ErrTimeout   = 3'd2;
  localparam logic [2:0] ErrUnexpData = 3'd3;
  localparam logic [2:0] ErrAddrRange = 3'd4;

  typedef enum logic [2:0] {
    StIdle, StGap, StCmd, StWdata, StRdata, StNext, StDone, StFail
  } state_e;

endpackage

// File: rtl/oram_addr_seq.sv
// Divider-free address walker: Addr_n = (n / Period) * Stride + n % Stride.
// Advance steps n by one; Addr is valid combinationally from the counters.
module oram_addr_seq #(
  parameter int unsigned ORAMU  = 32,
  parameter int unsigned Stride = 73,
  parameter int unsigned Period = 2117
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Advance,
  output logic [ORAMU-1:0] Addr
);

  logic [ORAMU-1:0] inner_q, group_q, base_q;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      inner_q <= '0;
      group_q <= '0;
      base_q  <= '0;
    end else if (Advance) begin
      if (group_q == ORAMU'(Period - 1)) begin
        // End of a group: shift the window up by one stride and restart it.
        group_q <= '0;
        inner_q <= '0;
        base_q  <= base_q + ORAMU'(Stride);
      end else begin
        group_q <= group_q + ORAMU'(1);
        inner_q <= (inner_q == ORAMU'(Stride - 1)) ? '0 : inner_q + ORAMU'(1);
      end
    end
  end

  assign Addr = base_q + inner_q;

endmodule

// File: rtl/oram_traffic_gen.sv
// On-chip initiator/checker for the ORAM front-end port: issues a fixed
// Append/Read/ReadRmv stream, checks returned blocks, reports pass/fail.
module oram_traffic_gen
  import oram_traffic_gen_pkg::*;
#(
  parameter int unsigned ORAMU         = 32,
  parameter int unsigned ORAMB         = 512,
  parameter int unsigned FEDWidth      = 64,
  parameter int unsigned NumTestBlocks = 256,
  parameter int unsigned NumAccesses   = 400,
  parameter int unsigned Stride        = 73,
  parameter int unsigned Period        = 2117,
  parameter int unsigned GapCycles     = 100,
  parameter int unsigned TimeoutCycles = 65535
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  output logic [1:0]          Cmd,
  output logic [ORAMU-1:0]    PAddr,
  output logic                CmdValid,
  input  logic                CmdReady,
  output logic [FEDWidth-1:0] DataIn,
  output logic                DataInValid,
  input  logic                DataInReady,
  input  logic [FEDWidth-1:0] DataOut,
  input  logic                DataOutValid,
  output logic                DataOutReady,
  output logic                Done,
  output logic                Pass,
  output logic [2:0]          ErrCode,
  output logic [ORAMU-1:0]    ErrAddr,
  output logic [31:0]         AccessCount
);

  localparam int unsigned FEORAMBChunks = ORAMB / FEDWidth;
  localparam int unsigned ChunkW        = $clog2(FEORAMBChunks);
  localparam int unsigned IdxW          = $clog2(NumTestBlocks);

  state_e                   state_q, state_d;
  logic [31:0]              gap_q, gap_d, tmo_q, tmo_d, acc_q, acc_d;
  logic [ChunkW-1:0]        chunk_q, chunk_d;
  logic [1:0]               op_q, op_d;
  logic [NumTestBlocks-1:0] exist_q, exist_d, toggle_q, toggle_d;
  logic [2:0]               err_q, err_d;
  logic [ORAMU-1:0]         err_addr_q, err_addr_d;

  logic                advance;
  logic [ORAMU-1:0]    addr;
  logic [IdxW-1:0]     idx;
  logic [FEDWidth-1:0] chunk_val;
  logic                last_chunk;
  logic                spurious;

  oram_addr_seq #(
    .ORAMU  (ORAMU),
    .Stride (Stride),
    .Period (Period)
  ) u_addr_seq (
    .Clock   (Clock),
    .Reset   (Reset),
    .Advance (advance),
    .Addr    (addr)
  );

  assign idx        = addr[IdxW-1:0];
  assign chunk_val  = FEDWidth'(addr) + FEDWidth'(chunk_q);
  assign last_chunk = (chunk_q == ChunkW'(FEORAMBChunks - 1));
  assign spurious   = DataOutValid && (state_q inside {StGap, StCmd, StWdata, StNext});

  always_ff @(posedge Clock) begin
    if (!Reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      gap_q      <= '0;
      tmo_q      <= '0;
      acc_q      <= '0;
      chunk_q    <= '0;
      op_q       <= BECMD_Update;
      exist_q    <= '0;
      toggle_q   <= '0;
      err_q      <= ErrNone;
      err_addr_q <= '0;
    end else begin
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      acc_q      <= acc_d;
      chunk_q    <= chunk_d;
      op_q       <= op_d;
      exist_q    <= exist_d;
      toggle_q   <= toggle_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    acc_d      = acc_q;
    chunk_d    = chunk_q;
    op_d       = op_q;
    exist_d    = exist_q;
    toggle_d   = toggle_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    advance    = 1'b0;
    if (spurious) begin
      state_d    = StFail;
      err_d      = ErrUnexpData;
      err_addr_d = addr;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            state_d = StGap;
            gap_d   = '0;
          end
        end
        StGap: begin
          gap_d = gap_q + 32'd1;
          if (gap_q == 32'(GapCycles - 1)) begin
            if (acc_q == 32'(NumAccesses)) begin
              state_d = StDone;
            end else if (addr >= ORAMU'(NumTestBlocks)) begin
              state_d    = StFail;
              err_d      = ErrAddrRange;
              err_addr_d = addr;
            end else begin
              state_d = StCmd;
              if (!exist_q[idx])       op_d = BECMD_Append;
              else if (!toggle_q[idx]) op_d = BECMD_Read;
              else                     op_d = BECMD_ReadRmv;
            end
          end
        end
        StCmd: begin
          if (CmdReady) begin
            acc_d   = acc_q + 32'd1;
            chunk_d = '0;
            tmo_d   = '0;
            if (op_q == BECMD_Append) begin
              exist_d[idx] = 1'b1;
              state_d      = StWdata;
            end else begin
              if (op_q == BECMD_Read) begin
                toggle_d[idx] = 1'b1;
              end else begin
                exist_d[idx]  = 1'b0;
                toggle_d[idx] = 1'b0;
              end
              state_d = StRdata;
            end
          end
        end
        StWdata: begin
          if (DataInReady) begin
            chunk_d = chunk_q + ChunkW'(1);
            if (last_chunk) state_d = StNext;
          end
        end
        StRdata: begin
          if (DataOutValid) begin
            // Case inequality so an X on the return bus is flagged in simulation.
            if (DataOut !== chunk_val) begin
              state_d    = StFail;
              err_d      = ErrMismatch;
              err_addr_d = addr;
            end else begin
              chunk_d = chunk_q + ChunkW'(1);
              tmo_d   = '0;
              if (last_chunk) state_d = StNext;
            end
          end else if (tmo_q == 32'(TimeoutCycles - 1)) begin
            state_d    = StFail;
            err_d      = ErrTimeout;
            err_addr_d = addr;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
        StNext: begin
          advance = 1'b1;
          state_d = StGap;
          gap_d   = '0;
        end
        StDone, StFail: begin
        end
      endcase
    end
  end

  always_comb begin
    Cmd          = BECMD_Update;
    PAddr        = '0;
    CmdValid     = 1'b0;
    DataIn       = '0;
    DataInValid  = 1'b0;
    DataOutReady = 1'b0;
    Done         = 1'b0;
    Pass         = 1'b0;
    ErrCode      = ErrNone;
    ErrAddr      = '0;
    AccessCount  = acc_q;
    case (state_q)
      StCmd: begin
        CmdValid = 1'b1;
        Cmd      = op_q;
        PAddr    = addr;
      end
      StWdata: begin
        DataInValid = 1'b1;
        DataIn      = chunk_val;
      end
      StRdata: DataOutReady = 1'b1;
      StDone: begin
        Done = 1'b1;
        Pass = 1'b1;
      end
      StFail: begin
        Done    = 1'b1;
        ErrCode = err_q;
        ErrAddr = err_addr_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_oram_traffic_gen.sv
// Bench for oram_traffic_gen: responder with random back-pressure and an
// ideal memory, checked against an address/op model plus directed corner cases.
module tb_oram_traffic_gen;

  localparam int unsigned S = 4;
  localparam int unsigned P = 8;
  localparam int unsigned NAcc = 24;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Cmd;
  logic [31:0] PAddr;
  logic        CmdValid;
  logic        CmdReady = 1'b0;
  logic [63:0] DataIn;
  logic        DataInValid;
  logic        DataInReady = 1'b0;
  logic [63:0] DataOut = '0;
  logic        DataOutValid = 1'b0;
  logic        DataOutReady;
  logic        Done;
  logic        Pass;
  logic [2:0]  ErrCode;
  logic [31:0] ErrAddr;
  logic [31:0] AccessCount;

  logic        seq_adv = 1'b0;
  logic [31:0] seq_addr;

  always #5 Clock = ~Clock;

  oram_traffic_gen #(
    .ORAMU         (32),
    .ORAMB         (512),
    .FEDWidth      (64),
    .NumTestBlocks (256),
    .NumAccesses   (NAcc),
    .Stride        (S),
    .Period        (P),
    .GapCycles     (3),
    .TimeoutCycles (16)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Start        (Start),
    .Cmd          (Cmd),
    .PAddr        (PAddr),
    .CmdValid     (CmdValid),
    .CmdReady     (CmdReady),
    .DataIn       (DataIn),
    .DataInValid  (DataInValid),
    .DataInReady  (DataInReady),
    .DataOut      (DataOut),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady),
    .Done         (Done),
    .Pass         (Pass),
    .ErrCode      (ErrCode),
    .ErrAddr      (ErrAddr),
    .AccessCount  (AccessCount)
  );

  oram_addr_seq #(
    .ORAMU  (32),
    .Stride (3),
    .Period (6)
  ) u_seq (
    .Clock   (Clock),
    .Reset   (Reset),
    .Advance (seq_adv),
    .Addr    (seq_addr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int seen[int];
  logic [63:0] mem[int];

  typedef struct {
    logic        adv;
    logic [31:0] exp;
  } seq_vec_t;
  seq_vec_t tbl[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 64'({CmdValid, DataInValid, DataOutReady, Done, Pass, ErrCode, Cmd}), 0);
    check({tag, "_paddr_acc"}, {PAddr, AccessCount}, 0);
    check({tag, "_din"}, DataIn, 0);
    check({tag, "_erraddr"}, 64'(ErrAddr), 0);
  endtask

  task automatic do_reset();
    Reset = 1'b0; Start = 1'b0; CmdReady = 1'b0; DataInReady = 1'b0;
    DataOutValid = 1'b0; DataOut = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    seen.delete();
    mem.delete();
  endtask

  // One access as the model expects it: address from the closed-form formula,
  // op from how many times that address has been touched (mod 3).
  task automatic do_access(input int n, input int hold, input int din_mode,
                           input int corrupt, input bit no_data);
    int a, cnt, op, bad, k, cyc, gap;
    logic [63:0] got[8];
    logic [63:0] v;
    a   = (n / P) * S + n % S;
    cnt = seen.exists(a) ? seen[a] : 0;
    op  = cnt % 3 + 1;
    cyc = 0;
    while (!CmdValid && cyc < 200) begin
      @(negedge Clock);
      cyc++;
    end
    check($sformatf("cmd_valid_n%0d", n), 64'(CmdValid), 1);
    if (!CmdValid) return;
    check($sformatf("cmd_n%0d", n), 64'(Cmd), 64'(op));
    check($sformatf("paddr_n%0d", n), 64'(PAddr), 64'(a));
    check($sformatf("acc_pre_n%0d", n), 64'(AccessCount), 64'(n));
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clock);
      if (!CmdValid || Cmd !== 2'(op) || PAddr !== 32'(a) || AccessCount !== 32'(n)) bad++;
    end
    if (hold > 0) check($sformatf("cmd_stable_n%0d", n), 64'(bad), 0);
    CmdReady = 1'b1;
    @(negedge Clock);
    CmdReady = 1'b0;
    check($sformatf("acc_post_n%0d", n), 64'(AccessCount), 64'(n + 1));
    seen[a] = cnt + 1;
    if (op == 1) begin
      k = 0;
      cyc = 0;
      while (k < 8 && cyc < 200) begin
        if (DataInValid) begin
          DataInReady = (din_mode == 0) ? 1'b1 : (din_mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
          if (DataInReady) begin
            got[k] = DataIn;
            k++;
          end
        end else begin
          DataInReady = 1'b0;
        end
        @(negedge Clock);
        cyc++;
      end
      DataInReady = 1'b0;
      check($sformatf("din_count_n%0d", n), 64'(k), 8);
      check($sformatf("din_extra_n%0d", n), 64'(DataInValid), 0);
      for (int j = 0; j < k; j++) begin
        check($sformatf("din_n%0d_c%0d", n, j), got[j], 64'(a + j));
        mem[a * 8 + j] = got[j];
      end
    end else begin
      if (no_data) return;
      check($sformatf("dout_ready_n%0d", n), 64'(DataOutReady), 1);
      for (int j = 0; j < 8; j++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge Clock);
        v = mem.exists(a * 8 + j) ? mem[a * 8 + j] : 64'(a + j);
        DataOut = (j == corrupt) ? v + 64'd1 : v;
        DataOutValid = 1'b1;
        @(negedge Clock);
        DataOutValid = 1'b0;
        if (j == corrupt) return;
      end
      check($sformatf("dout_ready_after_n%0d", n), 64'(DataOutReady), 0);
    end
  endtask

  initial begin
    int cyc;
    tbl = '{'{1, 0}, '{1, 1}, '{0, 2}, '{1, 2}, '{1, 0}, '{1, 1}, '{1, 2}, '{0, 3},
            '{1, 3}, '{1, 4}, '{1, 5}, '{1, 3}, '{1, 4}, '{1, 5}, '{1, 6}, '{0, 7}};

    // Reset state
    repeat (3) @(negedge Clock);
    check_all_zero("reset");
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    check("idle_no_start", {CmdValid, 31'd0, AccessCount}, 0);

    // Address sequencer on its own
    for (int i = 0; i < 16; i++) begin
      check($sformatf("seq_%0d", i), 64'(seq_addr), 64'(tbl[i].exp));
      seq_adv = tbl[i].adv;
      @(negedge Clock);
    end
    seq_adv = 1'b0;

    // Full run: random back-pressure, long CmdReady stall, toggling DataInReady
    do_reset();
    Start = 1'b1;
    for (int n = 0; n < NAcc; n++)
      do_access(n, (n == 0) ? 50 : int'($urandom_range(0, 3)),
                (n == 1) ? 1 : int'($urandom_range(0, 2)), -1, 1'b0);
    cyc = 0;
    while (!Done && cyc < 50) begin
      @(negedge Clock);
      cyc++;
    end
    check("run_done", 64'(Done), 1);
    check("run_pass", 64'(Pass), 1);
    check("run_errcode", 64'(ErrCode), 0);
    check("run_acc", 64'(AccessCount), 64'(NAcc));

    // Corrupted read chunk 3 of address 2
    do_reset();
    Start = 1'b1;
    for (int n = 0; n < 6; n++) do_access(n, $urandom_range(0, 2), 2, -1, 1'b0);
    do_access(6, 0, 0, 3, 1'b0);
    check("mm_done", 64'(Done), 1);
    check("mm_pass", 64'(Pass), 0);
    check("mm_errcode", 64'(ErrCode), 1);
    check("mm_erraddr", 64'(ErrAddr), 2);
    check("mm_dout_ready", 64'(DataOutReady), 0);

    // Read with no data returned
    do_reset();
    Start = 1'b1;
    for (int n = 0; n < 4; n++) do_access(n, 0, 0, -1, 1'b0);
    do_access(4, 0, 0, -1, 1'b1);
    cyc = 0;
    while (!Done && cyc < 40) begin
      @(negedge Clock);
      cyc++;
    end
    check("tmo_cycles", 64'(cyc), 16);
    check("tmo_errcode", 64'(ErrCode), 2);
    check("tmo_erraddr", 64'(ErrAddr), 0);

    // Spurious read data during GAP
    do_reset();
    Start = 1'b1;
    @(negedge Clock);
    DataOutValid = 1'b1;
    @(negedge Clock);
    DataOutValid = 1'b0;
    check("spur_done", 64'(Done), 1);
    check("spur_pass", 64'(Pass), 0);
    check("spur_errcode", 64'(ErrCode), 3);

    // Reset while streaming write chunk 4
    do_reset();
    Start = 1'b1;
    cyc = 0;
    while (!CmdValid && cyc < 50) begin
      @(negedge Clock);
      cyc++;
    end
    CmdReady = 1'b1;
    @(negedge Clock);
    CmdReady = 1'b0;
    DataInReady = 1'b1;
    repeat (4) @(negedge Clock);
    check("wr_chunk4", DataIn, 4);
    Reset = 1'b0;
    Start = 1'b0;
    DataInReady = 1'b0;
    @(negedge Clock);
    check_all_zero("midreset");
    Reset = 1'b1;
    seen.delete();
    mem.delete();
    repeat (5) @(negedge Clock);
    check("midreset_idle", {CmdValid, 31'd0, AccessCount}, 0);
    Start = 1'b1;
    do_access(0, 0, 0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oram_traffic_gen.md
Name: oram_traffic_gen

Overview:
- Synthesizable on-chip initiator and checker for the TinyORAMCore front-end port (Cmd/PAddr/DataIn/DataOut).
- Issues a deterministic stream of Append/Read/ReadRmv commands and streams FEDWidth write chunks.
- Checks every returned block against a known pattern, then reports pass/fail.
- Used for FPGA bring-up in place of a host, alongside the DRAM-side model.

Parameters:
- ORAMU, 32, program address width
- ORAMB, 512, block size in bits
- FEDWidth, 64, front-end chunk width; FEORAMBChunks = ORAMB/FEDWidth
- NumTestBlocks, 256, tracked addresses; power of two
- NumAccesses, 400, total commands before Done
- Stride, 73, inner address modulus (nn)
- Period, 2117, accesses per group (Stride*29)
- GapCycles, 100, idle cycles between commands
- TimeoutCycles, 65535, maximum wait for each read chunk

Ports:
- Clock, in, 1, sole clock
- Reset, in, 1, synchronous, active-low; asserted when Reset==0 at posedge Clock
- Start, in, 1, level; run begins on the first cycle it is high in IDLE
- Cmd, out, 2, front-end command: Update=0, Append=1, Read=2, ReadRmv=3
- PAddr, out, ORAMU, block address
- CmdValid, out, 1, command valid
- CmdReady, in, 1, command accepted
- DataIn, out, FEDWidth, write chunk
- DataInValid, out, 1, write chunk valid
- DataInReady, in, 1, write chunk accepted
- DataOut, in, FEDWidth, read chunk
- DataOutValid, in, 1, read chunk valid
- DataOutReady, out, 1, read chunk accepted
- Done, out, 1, run finished (sticky)
- Pass, out, 1, Done with no error (sticky)
- ErrCode, out, 3, 0 none, 1 mismatch, 2 timeout, 3 unexpected data, 4 address out of range
- ErrAddr, out, ORAMU, address of the failing access
- AccessCount, out, 32, commands accepted so far

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, Exist and Toggle bitmaps are cleared, address counters are cleared. Reset mid-transaction abandons it immediately and DataOutReady drops.
- FSM states and transitions:
  - IDLE: on Start -> GAP.
  - GAP: count GapCycles, then -> CMD. If AccessCount==NumAccesses -> DONE instead.
  - CMD: CmdValid=1 with Cmd and PAddr stable until CmdReady. On the handshake, AccessCount++ and the bitmaps update. Next state: Append -> WDATA; Read or ReadRmv -> RDATA.
  - WDATA: DataInValid=1. Chunk i carries DataIn = zero-extended Addr + i, chunk 0 first. i advances only on DataInValid&DataInReady. After chunk FEORAMBChunks-1 -> NEXT.
  - RDATA: DataOutReady=1. Each handshake compares DataOut with Addr + i. A mismatch -> FAIL with ErrCode=1. The timeout counter resets on each chunk; if it reaches TimeoutCycles -> FAIL with ErrCode=2. After the last chunk -> NEXT.
  - NEXT: advance the address (one cycle), then -> GAP.
  - DONE: Done=1, Pass=1, terminal until reset.
  - FAIL: Done=1, Pass=0, ErrCode and ErrAddr latched, terminal.
- Op selection, evaluated in GAP's last cycle:
  - !Exist[a] -> Append; set Exist.
  - Exist & !Toggle[a] -> Read; set Toggle.
  - Exist & Toggle[a] -> ReadRmv; clear Exist and Toggle.
- Address sequence: Addr_n = (n/Period)*Stride + n%Stride, built without dividers.
  - Inner counter wraps Stride-1 -> 0.
  - Group counter wraps Period-1 -> 0; on that wrap, Base += Stride and the inner counter is forced to 0.
  - Addr = Base + inner.
  - Addr >= NumTestBlocks at CMD entry -> FAIL with ErrCode=4, and no command is issued.
- DataOutValid in any state other than RDATA (IDLE/DONE/FAIL excluded) -> FAIL with ErrCode=3.
- DataOutReady is low outside RDATA.
- Handshake outputs are registered; each valid, once raised, stays high until its handshake completes.
- The returned-data check treats any X as a mismatch (sim only).

Decomposition:
- Shared package (or constants header):
  - BECMD_Update/Append/Read/ReadRmv encodings
  - ErrCode constants
  - FSM state encodings
- One sub-module: oram_addr_seq. It holds the inner, group and Base counters, takes an advance pulse and outputs Addr. Directed-tested on its own.

Test Plan:
- Responder always ready, ideal memory; Stride=4, Period=8, NumAccesses=24 -> address order 0,1,2,3,0,1,2,3,4,5,6,7,4,… Ops are Append,Append,Append,Append,Read,Read,… Done=1, Pass=1, AccessCount=24.
- Read chunk 3 for addr 2 returns 0x6 instead of 0x5 -> FAIL, ErrCode=1, ErrAddr=2, DataOutReady=0 the next cycle.
- CmdReady held low for 50 cycles -> CmdValid, Cmd and PAddr stay stable for all 50 cycles. One command is accepted; AccessCount increments once.
- DataInReady toggles every other cycle -> exactly 8 chunks with values Addr+0..Addr+7, none duplicated or skipped.
- No read data within TimeoutCycles=16 -> FAIL with ErrCode=2. A spurious DataOutValid during GAP -> FAIL with ErrCode=3.
- Reset pulled low while in WDATA, chunk 4 -> next cycle all outputs are 0 and the FSM is in IDLE. After Start, addr 0 is an Append again.
